// File: rtl/sa_tile_if.sv
// Handshake and bus bundle between the tile scheduler, its host and the systolic array.
interface sa_tile_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              go;
    logic [CNT_W-1:0]  cfg_m_tiles;
    logic [CNT_W-1:0]  cfg_k_tiles;
    logic [CNT_W-1:0]  cfg_c_tiles;
    logic [ADDR_W-1:0] cfg_x_base;
    logic [ADDR_W-1:0] cfg_w_base;
    logic [ADDR_W-1:0] x_addr;
    logic [ADDR_W-1:0] w_addr;
    logic              start_mul;
    logic              stall_mul;
    logic              psum_clear;
    logic              wb_valid;
    logic              wb_ready;
    logic [CNT_W-1:0]  wb_m;
    logic [CNT_W-1:0]  wb_c;
    logic              busy;
    logic              done;
    logic              err_timeout;

    // Scheduler side
    modport master (
        input  go, cfg_m_tiles, cfg_k_tiles, cfg_c_tiles, cfg_x_base, cfg_w_base,
        input  stall_mul, wb_ready,
        output x_addr, w_addr, start_mul, psum_clear,
        output wb_valid, wb_m, wb_c, busy, done, err_timeout
    );

    // Host / array / writeback side
    modport slave (
        output go, cfg_m_tiles, cfg_k_tiles, cfg_c_tiles, cfg_x_base, cfg_w_base,
        output stall_mul, wb_ready,
        input  x_addr, w_addr, start_mul, psum_clear,
        input  wb_valid, wb_m, wb_c, busy, done, err_timeout
    );
endinterface

// File: rtl/sa_tile_scheduler.sv
// Tiled GEMM sequencer for an N x N systolic array: walks m (outer), c, k (inner),
// issues one multiply per k tile and hands each finished (m,c) tile to writeback.
module sa_tile_scheduler #(
    parameter int N            = 4,
    parameter int ADDR_W       = 32,
    parameter int CNT_W        = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic      clk,
    input  logic      n_rst,
    sa_tile_if.master bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_WB        = 3'd4;
    localparam logic [2:0] S_FIN       = 3'd5;

    // A tile is N*N words; N is a power of two so strides are plain shifts.
    localparam int                TS_SH = 2 * $clog2(N);
    localparam logic [ADDR_W-1:0] TS    = ADDR_W'(N * N);
    localparam int                TMR_W = $clog2(BUSY_TIMEOUT + 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  m_q, m_d, c_q, c_d, k_q, k_d;
    logic [CNT_W-1:0]  mt_q, mt_d, kt_q, kt_d, ct_q, ct_d;
    logic [ADDR_W-1:0] xs_q, xs_d, ws_q, ws_d;          // row stride of X, k stride of W
    logic [ADDR_W-1:0] w_base_q, w_base_d;
    logic [ADDR_W-1:0] x_row_q, x_row_d;                // X tile (m,0)
    logic [ADDR_W-1:0] w_col_q, w_col_d;                // W tile (0,c)
    logic [ADDR_W-1:0] x_addr_q, x_addr_d, w_addr_q, w_addr_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              err_q, err_d;

    // Next-state and address walk; addresses only ever move by adds of registered strides
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        c_d      = c_q;
        k_d      = k_q;
        mt_d     = mt_q;
        kt_d     = kt_q;
        ct_d     = ct_q;
        xs_d     = xs_q;
        ws_d     = ws_q;
        w_base_d = w_base_q;
        x_row_d  = x_row_q;
        w_col_d  = w_col_q;
        x_addr_d = x_addr_q;
        w_addr_d = w_addr_q;
        tmr_d    = tmr_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    mt_d     = bus.cfg_m_tiles;
                    kt_d     = bus.cfg_k_tiles;
                    ct_d     = bus.cfg_c_tiles;
                    xs_d     = ADDR_W'(bus.cfg_k_tiles) << TS_SH;
                    ws_d     = ADDR_W'(bus.cfg_c_tiles) << TS_SH;
                    w_base_d = bus.cfg_w_base;
                    x_row_d  = bus.cfg_x_base;
                    w_col_d  = bus.cfg_w_base;
                    err_d    = 1'b0;
                    m_d      = '0;
                    c_d      = '0;
                    k_d      = '0;
                    if (bus.cfg_m_tiles == '0 || bus.cfg_k_tiles == '0 ||
                        bus.cfg_c_tiles == '0) begin
                        state_d = S_FIN;
                    end else begin
                        x_addr_d = bus.cfg_x_base;
                        w_addr_d = bus.cfg_w_base;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // The issue cycle already counts toward the busy timeout
                tmr_d   = TMR_W'(1);
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.stall_mul) begin
                    state_d = S_WAIT_DONE;
                end else if (tmr_q >= TMR_W'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!bus.stall_mul) begin
                    if (k_q != kt_q - CNT_W'(1)) begin
                        k_d      = k_q + CNT_W'(1);
                        x_addr_d = x_addr_q + TS;
                        w_addr_d = w_addr_q + ws_q;
                        state_d  = S_ISSUE;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                if (bus.wb_ready) begin
                    k_d = '0;
                    if (c_q == ct_q - CNT_W'(1)) begin
                        c_d = '0;
                        if (m_q == mt_q - CNT_W'(1)) begin
                            state_d = S_FIN;
                        end else begin
                            m_d      = m_q + CNT_W'(1);
                            x_row_d  = x_row_q + xs_q;
                            w_col_d  = w_base_q;
                            x_addr_d = x_row_q + xs_q;
                            w_addr_d = w_base_q;
                            state_d  = S_ISSUE;
                        end
                    end else begin
                        c_d      = c_q + CNT_W'(1);
                        w_col_d  = w_col_q + TS;
                        x_addr_d = x_row_q;
                        w_addr_d = w_col_q + TS;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset returns to IDLE with every counter and address cleared
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            c_q      <= '0;
            k_q      <= '0;
            mt_q     <= '0;
            kt_q     <= '0;
            ct_q     <= '0;
            xs_q     <= '0;
            ws_q     <= '0;
            w_base_q <= '0;
            x_row_q  <= '0;
            w_col_q  <= '0;
            x_addr_q <= '0;
            w_addr_q <= '0;
            tmr_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            c_q      <= c_d;
            k_q      <= k_d;
            mt_q     <= mt_d;
            kt_q     <= kt_d;
            ct_q     <= ct_d;
            xs_q     <= xs_d;
            ws_q     <= ws_d;
            w_base_q <= w_base_d;
            x_row_q  <= x_row_d;
            w_col_q  <= w_col_d;
            x_addr_q <= x_addr_d;
            w_addr_q <= w_addr_d;
            tmr_q    <= tmr_d;
            err_q    <= err_d;
        end
    end

    assign bus.x_addr      = x_addr_q;
    assign bus.w_addr      = w_addr_q;
    assign bus.start_mul   = (state_q == S_ISSUE);
    assign bus.psum_clear  = (state_q == S_ISSUE) && (k_q == '0);
    assign bus.wb_valid    = (state_q == S_WB);
    assign bus.wb_m        = (state_q == S_WB) ? m_q : '0;
    assign bus.wb_c        = (state_q == S_WB) ? c_q : '0;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_FIN);
    assign bus.err_timeout = err_q;
endmodule
